fetch_unit: RTL and testbench

//  Program-counter and fetch stage of the 16-bit core; sits directly upstream of I_memory.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: word/address widths, NOP encoding, state enum.
package fetch_unit_pkg;

   localparam int ISIZE     = 16;
   localparam int MEM_SPACE = 8;

   typedef logic [MEM_SPACE-1:0] addr_t;
   typedef logic [ISIZE-1:0]     instr_t;

   localparam addr_t  RESET_PC_DEF = '0;
   localparam instr_t NOP_ENC      = 16'h7000;

   typedef enum logic [1:0] {
      ST_BUBBLE = 2'd0,
      ST_RUN    = 2'd1,
      ST_HOLD   = 2'd2
   } fetch_state_e;

   // PC arithmetic wraps modulo 2^MEM_SPACE with no overflow flag.
   function automatic addr_t pc_inc(input addr_t pc);
      return pc + addr_t'(1);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall inputs, I_memory address/data and decode-facing outputs.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic   stall;
   logic   branch_taken;
   addr_t  branch_target;
   addr_t  imem_addr;
   instr_t imem_data;
   instr_t imem_next_data;
   instr_t instr_out;
   addr_t  pc_out;
   logic   instr_valid;
   instr_t next_instr_out;
   logic   next_valid;

   modport master (
      input  stall, branch_taken, branch_target, imem_data, imem_next_data,
      output imem_addr, instr_out, pc_out, instr_valid, next_instr_out, next_valid
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_data, imem_next_data,
      input  imem_addr, instr_out, pc_out, instr_valid, next_instr_out, next_valid
   );

endinterface

// File: rtl/fetch_unit.sv
// PC + fetch stage: hides the 1-cycle I_memory latency, 1-entry skid for stalls, branch flush.
// Optional FETCH_LOOKAHEAD_EN exposes the pc+1 instruction alongside the current one.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_BUBBLE | no read in flight, skid empty; outputs NOP, instr_valid=0
// ST_RUN    | read of r_req_pc in flight, imem_data presented directly
// ST_HOLD   | stalled; skid holds the presented instr, r_pc re-issued to memory
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter addr_t  RESET_PC  = RESET_PC_DEF,
   parameter instr_t NOP_INSTR = NOP_ENC
) (
   input  logic         i_clk,
   input  logic         i_rst,
   fetch_unit_if.master fetch
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   addr_t        r_pc;
   addr_t        w_pc_nxt;
   addr_t        r_req_pc;
   addr_t        w_req_pc_nxt;
   logic         w_skid_load;
   instr_t       r_skid_instr;
   addr_t        r_skid_pc;
   logic         w_instr_valid;
   logic         w_skid_full;

   assign w_skid_full   = (r_state == ST_HOLD);
   assign w_instr_valid = (r_state != ST_BUBBLE);

   // Branch beats stall beats advance; a stalled bubble is not worth holding.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_skid_load  = 1'b0;
      if (fetch.branch_taken) begin
         w_state_nxt = ST_BUBBLE;
         w_pc_nxt    = fetch.branch_target;
      end else if (fetch.stall && w_instr_valid) begin
         w_state_nxt  = ST_HOLD;
         w_req_pc_nxt = r_pc;
         w_skid_load  = !w_skid_full;
      end else begin
         w_state_nxt  = ST_RUN;
         w_pc_nxt     = pc_inc(r_pc);
         w_req_pc_nxt = r_pc;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_BUBBLE;
         r_pc         <= RESET_PC;
         r_req_pc     <= RESET_PC;
         r_skid_instr <= NOP_INSTR;
         r_skid_pc    <= RESET_PC;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_req_pc <= w_req_pc_nxt;
         if (w_skid_load) begin
            r_skid_instr <= fetch.imem_data;
            r_skid_pc    <= r_req_pc;
         end
      end
   end

   assign fetch.imem_addr   = r_pc;
   assign fetch.instr_valid = w_instr_valid;
   assign fetch.pc_out      = w_skid_full ? r_skid_pc : r_req_pc;
   assign fetch.instr_out   = w_skid_full   ? r_skid_instr :
                              w_instr_valid ? fetch.imem_data : NOP_INSTR;

`ifdef FETCH_LOOKAHEAD_EN
   instr_t r_skid_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_skid_next <= NOP_INSTR;
      end else if (w_skid_load) begin
         r_skid_next <= fetch.imem_next_data;
      end
   end

   // Nothing follows the top of the address space, so lookahead is invalid there.
   assign fetch.next_instr_out = w_skid_full ? r_skid_next : fetch.imem_next_data;
   assign fetch.next_valid     = w_instr_valid && (fetch.pc_out != '1);
`else
   logic w_unused_next;

   assign w_unused_next        = ^fetch.imem_next_data;
   assign fetch.next_instr_out = NOP_INSTR;
   assign fetch.next_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a synchronous I_memory model with mem[i]=16'h1000+i.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   fetch_unit_if fif ();

   fetch_unit dut (
      .i_clk (clk),
      .i_rst (rst),
      .fetch (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      fif.imem_data      <= 16'h1000 + {8'h00, fif.imem_addr};
      fif.imem_next_data <= 16'h1000 + {8'h00, fif.imem_addr + 8'd1};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] pc,
                             input logic [15:0] ins);
      logic nv;
      check({tag, ".valid"}, 32'(fif.instr_valid), 32'(v));
      check({tag, ".instr"}, 32'(fif.instr_out), 32'(ins));
      if (v) check({tag, ".pc"}, 32'(fif.pc_out), 32'(pc));
`ifdef FETCH_LOOKAHEAD_EN
      nv = v && (pc != 8'hFF);
      check({tag, ".nvalid"}, 32'(fif.next_valid), 32'(nv));
      if (nv) check({tag, ".ninstr"}, 32'(fif.next_instr_out), 32'(16'h1000 + {8'h00, pc + 8'd1}));
`else
      nv = 1'b0;
      check({tag, ".nvalid"}, 32'(fif.next_valid), 32'(nv));
      check({tag, ".ninstr"}, 32'(fif.next_instr_out), 32'h7000);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      fif.stall = 1'b0;
      fif.branch_taken = 1'b0;
      fif.branch_target = 8'h00;
      repeat (2) step();

      // reset state
      expect_out("rst", 1'b0, 8'h00, 16'h7000);
      check("rst.pc_out", 32'(fif.pc_out), 32'h00);
      check("rst.imem_addr", 32'(fif.imem_addr), 32'h00);

      rst = 1'b0;
      expect_out("rel_c1", 1'b0, 8'h00, 16'h7000);
      step();
      expect_out("run0", 1'b1, 8'h00, 16'h1000);
      check("run0.imem_addr", 32'(fif.imem_addr), 32'h01);
      for (int i = 1; i <= 3; i++) begin
         step();
         expect_out("run", 1'b1, 8'(i), 16'h1000 + 16'(i));
      end

      // branch while pc_out=3
      fif.branch_taken = 1'b1;
      fif.branch_target = 8'h40;
      step();
      fif.branch_taken = 1'b0;
      expect_out("br_bub", 1'b0, 8'h00, 16'h7000);
      check("br_bub.imem_addr", 32'(fif.imem_addr), 32'h40);
      step();
      expect_out("br_tgt", 1'b1, 8'h40, 16'h1040);
      step();
      expect_out("br_tgt1", 1'b1, 8'h41, 16'h1041);

      // redirect to 4 to reach pc_out=5
      fif.branch_taken = 1'b1;
      fif.branch_target = 8'h04;
      step();
      fif.branch_taken = 1'b0;
      expect_out("br2_bub", 1'b0, 8'h00, 16'h7000);
      step();
      expect_out("br2_tgt", 1'b1, 8'h04, 16'h1004);
      step();
      expect_out("pre_stall", 1'b1, 8'h05, 16'h1005);

      // stall 3 cycles at pc_out=5
      fif.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("stall_hold", 1'b1, 8'h05, 16'h1005);
         check("stall_hold.imem_addr", 32'(fif.imem_addr), 32'h06);
      end
      fif.stall = 1'b0;
      step();
      expect_out("rel6", 1'b1, 8'h06, 16'h1006);
      check("rel6.imem_addr", 32'(fif.imem_addr), 32'h07);
      step();
      expect_out("rel7", 1'b1, 8'h07, 16'h1007);

      // branch and stall together while in HOLD
      fif.stall = 1'b1;
      step();
      expect_out("hold7", 1'b1, 8'h07, 16'h1007);
      fif.branch_taken = 1'b1;
      fif.branch_target = 8'hF0;
      step();
      fif.branch_taken = 1'b0;
      expect_out("brhold_bub", 1'b0, 8'h00, 16'h7000);
      check("brhold_bub.imem_addr", 32'(fif.imem_addr), 32'hF0);
      step();
      fif.stall = 1'b0;
      expect_out("brhold_tgt", 1'b1, 8'hF0, 16'h10F0);

      // run to the top of the address space and wrap
      for (int i = 8'hF1; i <= 8'hFF; i++) begin
         step();
         expect_out("top", 1'b1, 8'(i), 16'h1000 + 16'(i));
      end
      step();
      expect_out("wrap0", 1'b1, 8'h00, 16'h1000);
      check("wrap0.imem_addr", 32'(fif.imem_addr), 32'h01);
      step();
      expect_out("wrap1", 1'b1, 8'h01, 16'h1001);
      step();
      expect_out("wrap2", 1'b1, 8'h02, 16'h1002);

      // reset asserted mid-HOLD
      fif.stall = 1'b1;
      step();
      expect_out("hold2", 1'b1, 8'h02, 16'h1002);
      #2;
      rst = 1'b1;
      #1;
      expect_out("midrst", 1'b0, 8'h00, 16'h7000);
      check("midrst.pc_out", 32'(fif.pc_out), 32'h00);
      check("midrst.imem_addr", 32'(fif.imem_addr), 32'h00);
      fif.stall = 1'b0;
      step();
      rst = 1'b0;
      expect_out("rerel_c1", 1'b0, 8'h00, 16'h7000);
      step();
      expect_out("rerun0", 1'b1, 8'h00, 16'h1000);
      step();
      expect_out("rerun1", 1'b1, 8'h01, 16'h1001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
